// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the I-memory read handshake and
// buffers returned instructions ({instr, pc+4}) for the IF/ID register.
// Build option: define FETCH_PREFETCH_EN for a 2-entry prefetch buffer
// (default build uses a single entry).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        ifid_ready,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned Depth = 2;
`else
  localparam int unsigned Depth = 1;
`endif

  typedef enum logic [1:0] {StRun, StSquash, StDrainHalt, StHalted} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_old_addr, w_old_addr_nxt;
  logic [1:0]  r_count, w_count_nxt;
  logic [31:0] r_instr [Depth];
  logic [31:0] w_instr_nxt [Depth];
  logic [31:0] r_npc [Depth];
  logic [31:0] w_npc_nxt [Depth];

  logic        w_valid, w_pop, w_push;
  logic [1:0]  w_wr_idx;
  logic [31:0] w_target;

  assign w_valid  = (r_count != 2'd0);
  assign w_pop    = w_valid & ifid_ready;
  assign w_push   = ihit & iREN & (r_state == StRun) & ~redirect;
  // Slot the incoming entry lands in once the head has (possibly) shifted out.
  assign w_wr_idx = r_count - {1'b0, w_pop};
  assign w_target = redirect_pc & 32'hFFFF_FFFC;

  assign valid_o = w_valid;
  assign instr_o = w_valid ? r_instr[0] : 32'h0;
  assign npc_o   = w_valid ? r_npc[0] : 32'h0;

  // Memory request: address and enable per state.
  always_comb begin
    iREN     = 1'b0;
    imemaddr = r_pc;
    unique case (r_state)
      StRun:                 iREN = (r_count < 2'(Depth)) | w_pop;
      StSquash, StDrainHalt: begin
        iREN     = 1'b1;
        imemaddr = r_old_addr;
      end
      StHalted:              iREN = 1'b0;
      default:               iREN = 1'b0;
    endcase
  end

  // Next state, PC and buffer contents. Halt beats redirect beats push/pop.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_old_addr_nxt = r_old_addr;
    w_count_nxt    = r_count;
    w_instr_nxt    = r_instr;
    w_npc_nxt      = r_npc;
    unique case (r_state)
      StRun: begin
        if (halt || redirect) begin
          w_count_nxt = 2'd0;
          for (int i = 0; i < int'(Depth); i++) begin
            w_instr_nxt[i] = 32'h0;
            w_npc_nxt[i]   = 32'h0;
          end
        end
        if (halt) begin
          if (iREN && !ihit) begin
            w_state_nxt    = StDrainHalt;
            w_old_addr_nxt = r_pc;
          end else begin
            w_state_nxt = StHalted;
          end
        end else if (redirect) begin
          w_pc_nxt = w_target;
          // An issued request that has not completed must be drained and dropped.
          if (iREN && !ihit) begin
            w_state_nxt    = StSquash;
            w_old_addr_nxt = r_pc;
          end
        end else begin
          if (w_pop) begin
            for (int i = 0; i < int'(Depth) - 1; i++) begin
              w_instr_nxt[i] = r_instr[i+1];
              w_npc_nxt[i]   = r_npc[i+1];
            end
            w_instr_nxt[Depth-1] = 32'h0;
            w_npc_nxt[Depth-1]   = 32'h0;
          end
          if (w_push) begin
            for (int i = 0; i < int'(Depth); i++) begin
              if (w_wr_idx == 2'(i)) begin
                w_instr_nxt[i] = imemload;
                w_npc_nxt[i]   = r_pc + 32'd4;
              end
            end
            w_pc_nxt = r_pc + 32'd4;
          end
          w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
      end
      StSquash: begin
        if (halt) begin
          w_state_nxt = ihit ? StHalted : StDrainHalt;
        end else begin
          if (redirect) w_pc_nxt = w_target;
          if (ihit)     w_state_nxt = StRun;
        end
      end
      StDrainHalt: begin
        if (ihit) w_state_nxt = StHalted;
      end
      StHalted: begin
        w_state_nxt = StHalted;
      end
      default: w_state_nxt = StRun;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StRun;
      r_pc       <= RESET_PC;
      r_old_addr <= 32'h0;
      r_count    <= 2'd0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_instr[i] <= 32'h0;
        r_npc[i]   <= 32'h0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_old_addr <= w_old_addr_nxt;
      r_count    <= w_count_nxt;
      r_instr    <= w_instr_nxt;
      r_npc      <= w_npc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Memory model: data at address a is a ^ 32'h5A5A_0000, returned when ihit=1.
module tb_fetch_stage;

`ifdef FETCH_PREFETCH_EN
  localparam int Depth = 2;
`else
  localparam int Depth = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        ifid_ready;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] npc_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .iREN        (iREN),
    .imemaddr    (imemaddr),
    .imemload    (imemload),
    .ihit        (ihit),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .ifid_ready  (ifid_ready),
    .valid_o     (valid_o),
    .instr_o     (instr_o),
    .npc_o       (npc_o)
  );

  always #5 CLK = ~CLK;

  assign imemload = ihit ? (imemaddr ^ 32'h5A5A_0000) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] npc);
    check({tag, ".valid"}, 32'(valid_o), 32'(v));
    check({tag, ".instr"}, instr_o, ins);
    check({tag, ".npc"}, npc_o, npc);
  endtask

  task automatic req(input string tag, input logic ren, input logic [31:0] addr);
    check({tag, ".iren"}, 32'(iREN), 32'(ren));
    if (ren) check({tag, ".addr"}, imemaddr, addr);
  endtask

  task automatic do_reset();
    RST = 1'b1; ihit = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    halt = 1'b0; ifid_ready = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // Straight-line fetch, hit every cycle, consumer always ready.
    do_reset();
    ihit = 1'b1; settle();
    head("rst", 1'b0, 32'h0, 32'h0);
    req("c1", 1'b1, 32'h0);
    tick(); settle();
    req("c2", 1'b1, 32'h4);
    head("c2", 1'b1, 32'h5A5A_0000, 32'h4);
    tick(); settle();
    req("c3", 1'b1, 32'h8);
    head("c3", 1'b1, 32'h5A5A_0004, 32'h8);

    // Stalled consumer fills the buffer, then drains in order.
    do_reset();
    ifid_ready = 1'b0; ihit = 1'b1; settle();
    req("st1", 1'b1, 32'h0);
    tick(); settle();
    head("st2", 1'b1, 32'h5A5A_0000, 32'h4);
    check("st2.iren", 32'(iREN), (Depth == 2) ? 32'd1 : 32'd0);
    check("st2.addr", imemaddr, 32'h4);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      check("st.full.iren", 32'(iREN), 32'd0);
      check("st.full.addr", imemaddr, (Depth == 2) ? 32'h8 : 32'h4);
      head("st.full", 1'b1, 32'h5A5A_0000, 32'h4);
    end
    ifid_ready = 1'b1; settle();
    req("st.rel", 1'b1, (Depth == 2) ? 32'h8 : 32'h4);
    tick(); settle();
    head("st.d1", 1'b1, 32'h5A5A_0004, 32'h8);
    tick(); settle();
    head("st.d2", 1'b1, 32'h5A5A_0008, 32'hC);

    // Redirect while the request at 0x8 is outstanding.
    do_reset();
    ihit = 1'b1;
    tick(); tick();
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103; settle();
    req("rd.pend", 1'b1, 32'h8);
    tick();
    redirect = 1'b0; settle();
    head("rd.sq1", 1'b0, 32'h0, 32'h0);
    req("rd.sq1", 1'b1, 32'h8);
    tick(); settle();
    req("rd.sq2", 1'b1, 32'h8);
    tick();
    ihit = 1'b1; settle();
    req("rd.sq3", 1'b1, 32'h8);
    tick(); settle();
    head("rd.drop", 1'b0, 32'h0, 32'h0);
    req("rd.new", 1'b1, 32'h100);
    tick(); settle();
    head("rd.first", 1'b1, 32'h5A5A_0100, 32'h104);

    // Redirect with a same-cycle hit while a full buffer pops.
    do_reset();
    ifid_ready = 1'b0; ihit = 1'b1;
    tick(); tick();
    ifid_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; settle();
    head("rf.full", 1'b1, 32'h5A5A_0000, 32'h4);
    tick();
    redirect = 1'b0; settle();
    head("rf.empty", 1'b0, 32'h0, 32'h0);
    req("rf.tgt", 1'b1, 32'h200);
    tick(); settle();
    head("rf.first", 1'b1, 32'h5A5A_0200, 32'h204);

    // PC wraps past the top of the address space; low target bits dropped.
    do_reset();
    ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0; settle();
    head("wr.disc", 1'b0, 32'h0, 32'h0);
    req("wr.top", 1'b1, 32'hFFFF_FFFC);
    tick(); settle();
    head("wr.head", 1'b1, 32'hA5A5_FFFC, 32'h0);
    req("wr.zero", 1'b1, 32'h0);

    // Halt with a pending request: drain it, then stop for good.
    do_reset();
    halt = 1'b1; settle();
    tick();
    halt = 1'b0; settle();
    req("hl.drain", 1'b1, 32'h0);
    head("hl.drain", 1'b0, 32'h0, 32'h0);
    tick();
    ihit = 1'b1; settle();
    req("hl.hit", 1'b1, 32'h0);
    tick();
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h300; settle();
    check("hl.off", 32'(iREN), 32'd0);
    head("hl.off", 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      check("hl.stay", 32'(iREN), 32'd0);
      check("hl.stayv", 32'(valid_o), 32'd0);
    end

    // Reset out of HALTED.
    do_reset();
    settle();
    req("rs.halted", 1'b1, 32'h0);
    head("rs.halted", 1'b0, 32'h0, 32'h0);

    // Reset mid-request with a response arriving in the reset cycle.
    ihit = 1'b1;
    tick(); tick();
    ihit = 1'b0; settle();
    head("rs.pre", 1'b1, 32'h5A5A_0004, 32'h8);
    RST = 1'b1; ihit = 1'b1;
    tick();
    RST = 1'b0; ihit = 1'b0; settle();
    req("rs.mid", 1'b1, 32'h0);
    head("rs.mid", 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
